// File: rtl/mem_stage_lsu_if.sv
// Data-memory bus between the MEM-stage load/store unit (master) and data memory (slave).
// req/gnt: master holds req with stable addr/be/we/wdata until gnt, and the beat transfers
// in the gnt cycle. rvalid/rdata: one response per accepted request, at least one cycle after gnt.
interface mem_stage_lsu_if #(
  parameter int ADDR_W = 32
) ();
  logic              req;
  logic              we;
  logic [3:0]        be;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic              gnt;
  logic              rvalid;
  logic [31:0]       rdata;

  modport master (
    output req, we, be, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, be, addr, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: legality check, one bus transaction per access, load
// alignment/extension, pipeline stall until completion, and a timeout-based bus error.
module mem_stage_lsu #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int ADDR_W         = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [3:0]        MemRead_i,
  input  logic [3:0]        MemWrite_i,
  input  logic              LoadUnsigned_i,
  input  logic [ADDR_W-1:0] ALUResult_i,
  input  logic [31:0]       WriteData_i,
  input  logic              flush_i,
  output logic              stall_o,
  output logic [31:0]       ReadData_o,
  output logic              done_o,
  output logic              misalign_o,
  output logic              bus_err_o,
  output logic [1:0]        state_dbg,
  mem_stage_lsu_if.master   dmem
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        be_q;
  logic              we_q;
  logic [31:0]       wdata_q;
  logic              uns_q;
  logic [3:0]        size_q;
  logic [1:0]        lane_q;
  logic [15:0]       cnt_q;
  logic              mis_q;
  logic              err_q;
  logic [31:0]       rdata_q;

  logic [3:0]  mask;
  logic        pending;
  logic        illegal;
  logic        timeout_hit;
  logic        rsp_done;
  logic        to_fire;
  logic [31:0] shifted;
  logic [31:0] load_val;
  logic [31:0] wdata_rep;

  assign mask    = MemRead_i | MemWrite_i;
  assign pending = (mask != 4'b0000) && !flush_i;

  always_comb begin
    illegal = 1'b0;
    if ((MemRead_i != 4'b0000) && (MemWrite_i != 4'b0000)) illegal = 1'b1;
    if ((mask != 4'b0001) && (mask != 4'b0011) && (mask != 4'b1111)) illegal = 1'b1;
    if ((mask == 4'b0011) && ALUResult_i[0]) illegal = 1'b1;
    if ((mask == 4'b1111) && (ALUResult_i[1:0] != 2'b00)) illegal = 1'b1;
  end

  always_comb begin
    case (mask)
      4'b0001: wdata_rep = {4{WriteData_i[7:0]}};
      4'b0011: wdata_rep = {2{WriteData_i[15:0]}};
      default: wdata_rep = WriteData_i;
    endcase
  end

  // Halves always have lane_q[0]=0, so one byte-granular shift serves bytes and halves.
  assign shifted = dmem.rdata >> {lane_q, 3'b000};

  always_comb begin
    case (size_q)
      4'b0001: load_val = {{24{~uns_q & shifted[7]}}, shifted[7:0]};
      4'b0011: load_val = {{16{~uns_q & shifted[15]}}, shifted[15:0]};
      default: load_val = dmem.rdata;
    endcase
    if (we_q) load_val = 32'h0;
  end

  assign timeout_hit = (cnt_q == TO_LAST);
  assign rsp_done    = (state_q == S_WAIT) && dmem.rvalid;
  assign to_fire     = ((state_q == S_REQ) || (state_q == S_WAIT)) && timeout_hit && !rsp_done;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (pending) state_d = illegal ? S_DONE : S_REQ;
      end
      S_REQ: begin
        // A grant in the final budget cycle is abandoned; its response is never awaited.
        if (to_fire)       state_d = S_DONE;
        else if (dmem.gnt) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (rsp_done || to_fire) state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      be_q    <= 4'b0000;
      we_q    <= 1'b0;
      wdata_q <= 32'h0;
      uns_q   <= 1'b0;
      size_q  <= 4'b0000;
      lane_q  <= 2'b00;
      cnt_q   <= 16'h0;
      mis_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (pending) begin
            mis_q <= illegal;
            err_q <= 1'b0;
            if (illegal) begin
              rdata_q <= 32'h0;
            end else begin
              addr_q  <= {ALUResult_i[ADDR_W-1:2], 2'b00};
              be_q    <= mask << ALUResult_i[1:0];
              we_q    <= (MemWrite_i != 4'b0000);
              wdata_q <= wdata_rep;
              uns_q   <= LoadUnsigned_i;
              size_q  <= mask;
              lane_q  <= ALUResult_i[1:0];
              cnt_q   <= 16'h0;
            end
          end
        end
        S_REQ, S_WAIT: begin
          cnt_q <= cnt_q + 16'h1;
          if (rsp_done) begin
            rdata_q <= load_val;
          end else if (to_fire) begin
            err_q   <= 1'b1;
            rdata_q <= 32'h0;
          end
        end
        default: ;
      endcase
    end
  end

  assign stall_o    = ((state_q == S_IDLE) && pending) || (state_q == S_REQ) || (state_q == S_WAIT);
  assign done_o     = (state_q == S_DONE);
  assign misalign_o = (state_q == S_DONE) && mis_q;
  assign bus_err_o  = (state_q == S_DONE) && err_q;
  assign ReadData_o = rdata_q;
  assign state_dbg  = state_q;

  assign dmem.req   = (state_q == S_REQ);
  assign dmem.we    = we_q;
  assign dmem.be    = be_q;
  assign dmem.addr  = addr_q;
  assign dmem.wdata = wdata_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: a per-cycle expectation timeline built from
// transaction-level rules, checked every cycle, plus hand-computed literal results.
module tb_mem_stage_lsu;
  localparam int AW = 32;
  localparam int TO = 8;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  logic [3:0]    MemRead_i = 4'b0, MemWrite_i = 4'b0;
  logic          LoadUnsigned_i = 1'b0;
  logic [AW-1:0] ALUResult_i = '0;
  logic [31:0]   WriteData_i = 32'h0;
  logic          flush_i = 1'b0;
  logic          stall_o, done_o, misalign_o, bus_err_o;
  logic [31:0]   ReadData_o;
  logic [1:0]    state_dbg;

  mem_stage_lsu_if #(.ADDR_W(AW)) dmem ();

  mem_stage_lsu #(.TIMEOUT_CYCLES(TO), .ADDR_W(AW)) dut (
    .CLK(CLK), .RST(RST),
    .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i), .LoadUnsigned_i(LoadUnsigned_i),
    .ALUResult_i(ALUResult_i), .WriteData_i(WriteData_i), .flush_i(flush_i),
    .stall_o(stall_o), .ReadData_o(ReadData_o), .done_o(done_o),
    .misalign_o(misalign_o), .bus_err_o(bus_err_o), .state_dbg(state_dbg),
    .dmem(dmem)
  );

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic        stall;
    logic        req;
    logic        done;
    logic        mis;
    logic        err;
    logic        crd;
    logic [31:0] rd;
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wd;
  } rec_t;

  rec_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  bit   chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    rec_t r;
    wait (chk_en);
    forever begin
      @(negedge CLK);
      r = '0;
      if (exp_q.size() > 0) r = exp_q.pop_front();
      chk("stall", 32'(stall_o), 32'(r.stall));
      chk("req", 32'(dmem.req), 32'(r.req));
      chk("done", 32'(done_o), 32'(r.done));
      chk("misalign", 32'(misalign_o), 32'(r.mis));
      chk("bus_err", 32'(bus_err_o), 32'(r.err));
      if (r.crd) chk("rdata", ReadData_o, r.rd);
      if (r.req) begin
        chk("bus_addr", dmem.addr, r.addr);
        chk("bus_be", 32'(dmem.be), 32'(r.be));
        chk("bus_we", 32'(dmem.we), 32'(r.we));
        chk("bus_wdata", dmem.wdata, r.wd);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- model ----------------
  function automatic logic is_legal(input logic [3:0] rd, input logic [3:0] wr, input logic [31:0] a);
    logic [3:0] m;
    m = rd | wr;
    if (rd != 0 && wr != 0) return 1'b0;
    if (m != 4'b0001 && m != 4'b0011 && m != 4'b1111) return 1'b0;
    if (m == 4'b0011 && a[0]) return 1'b0;
    if (m == 4'b1111 && a[1:0] != 2'b00) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [31:0] exp_wd(input logic [3:0] m, input logic [31:0] d);
    if (m == 4'b0001) return {4{d[7:0]}};
    if (m == 4'b0011) return {2{d[15:0]}};
    return d;
  endfunction

  function automatic logic [31:0] exp_load(input logic [3:0] m, input logic u, input logic [31:0] a,
                                           input logic [31:0] d, input logic st);
    logic [31:0] v;
    if (st) return 32'h0;
    if (m == 4'b1111) return d;
    if (m == 4'b0011) begin
      v = (d >> (16 * a[1])) & 32'h0000FFFF;
      if (!u && v[15]) v = v | 32'hFFFF0000;
      return v;
    end
    v = (d >> (8 * a[1:0])) & 32'h000000FF;
    if (!u && v[7]) v = v | 32'hFFFFFF00;
    return v;
  endfunction

  // ---------------- driver ----------------
  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    MemRead_i = 4'b0; MemWrite_i = 4'b0; LoadUnsigned_i = 1'b0;
    ALUResult_i = '0; WriteData_i = 32'h0; flush_i = 1'b0;
  endtask

  // g = REQ cycles before gnt (>= TO means never), r = WAIT cycles up to and including rvalid.
  task automatic run_op(input logic [3:0] rd, input logic [3:0] wr, input logic uns,
                        input logic [31:0] a, input logic [31:0] wdat, input int g, input int r,
                        input logic [31:0] rdat, input logic [31:0] lit_rd,
                        input logic [31:0] lit_addr, input logic [3:0] lit_be, input logic [31:0] lit_wd);
    rec_t e, bus;
    logic legal;
    logic [3:0] m;
    legal = is_legal(rd, wr, a);
    m = rd | wr;
    MemRead_i = rd; MemWrite_i = wr; LoadUnsigned_i = uns; ALUResult_i = a; WriteData_i = wdat;
    e = '0; e.stall = 1'b1;
    exp_q.push_back(e);
    next_cycle();
    if (!legal) begin
      e = '0; e.done = 1'b1; e.mis = 1'b1; e.crd = 1'b1; e.rd = 32'h0;
      exp_q.push_back(e);
      @(negedge CLK);
      chk("lit_rdata", ReadData_o, lit_rd);
      next_cycle();
      clear_inputs();
      return;
    end
    bus = '0; bus.stall = 1'b1; bus.req = 1'b1; bus.addr = {a[31:2], 2'b00};
    bus.be = m << a[1:0]; bus.we = (wr != 0); bus.wd = exp_wd(m, wdat);
    if (g >= TO) begin
      for (int i = 0; i < TO; i++) begin
        exp_q.push_back(bus);
        if (i == 0) begin
          @(negedge CLK);
          chk("lit_addr", dmem.addr, lit_addr);
          chk("lit_be", 32'(dmem.be), 32'(lit_be));
          chk("lit_wdata", dmem.wdata, lit_wd);
        end
        next_cycle();
      end
      e = '0; e.done = 1'b1; e.err = 1'b1; e.crd = 1'b1; e.rd = 32'h0;
      exp_q.push_back(e);
      @(negedge CLK);
      chk("lit_rdata", ReadData_o, lit_rd);
      next_cycle();
      clear_inputs();
      dmem.rvalid = 1'b1; dmem.rdata = rdat;
      e = '0; e.crd = 1'b1; e.rd = 32'h0;
      exp_q.push_back(e);
      next_cycle();
      dmem.rvalid = 1'b0;
      return;
    end
    for (int i = 0; i <= g; i++) begin
      dmem.gnt = (i == g);
      exp_q.push_back(bus);
      if (i == 0) begin
        @(negedge CLK);
        chk("lit_addr", dmem.addr, lit_addr);
        chk("lit_be", 32'(dmem.be), 32'(lit_be));
        chk("lit_wdata", dmem.wdata, lit_wd);
      end
      next_cycle();
    end
    dmem.gnt = 1'b0;
    for (int i = 0; i < r; i++) begin
      dmem.rvalid = (i == r - 1);
      dmem.rdata  = (i == r - 1) ? rdat : $urandom;
      e = '0; e.stall = 1'b1;
      exp_q.push_back(e);
      next_cycle();
    end
    dmem.rvalid = 1'b0;
    e = '0; e.done = 1'b1; e.crd = 1'b1; e.rd = exp_load(m, uns, a, rdat, wr != 0);
    exp_q.push_back(e);
    @(negedge CLK);
    chk("lit_rdata", ReadData_o, lit_rd);
    next_cycle();
    clear_inputs();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rec_t e;
    dmem.gnt = 1'b0; dmem.rvalid = 1'b0; dmem.rdata = 32'h0;
    #12;
    chk("rst_stall", 32'(stall_o), 32'h0);
    chk("rst_req", 32'(dmem.req), 32'h0);
    chk("rst_rdata", ReadData_o, 32'h0);
    chk("rst_done", 32'(done_o), 32'h0);
    chk("rst_addr", dmem.addr, 32'h0);
    next_cycle();
    RST = 1'b0;
    chk_en = 1'b1;
    next_cycle();

    // rd, wr, uns, addr, wdata, g, r, rdata, lit_rd, lit_addr, lit_be, lit_wd
    run_op(4'b1111, 4'b0000, 1'b0, 32'h100, 32'h0, 0, 2, 32'hDEADBEEF, 32'hDEADBEEF, 32'h100, 4'b1111, 32'h0);
    run_op(4'b0001, 4'b0000, 1'b0, 32'h103, 32'h0, 0, 1, 32'h80112233, 32'hFFFFFF80, 32'h100, 4'b1000, 32'h0);
    run_op(4'b0001, 4'b0000, 1'b1, 32'h103, 32'h0, 1, 2, 32'h80112233, 32'h00000080, 32'h100, 4'b1000, 32'h0);
    run_op(4'b0000, 4'b0011, 1'b0, 32'h0E, 32'h0000ABCD, 3, 1, 32'h55555555, 32'h0, 32'h0C, 4'b1100, 32'hABCDABCD);
    run_op(4'b1111, 4'b0000, 1'b0, 32'h102, 32'h0, 0, 1, 32'h0, 32'h0, 32'h0, 4'b0000, 32'h0);
    run_op(4'b0011, 4'b0000, 1'b0, 32'h101, 32'h0, 0, 1, 32'h0, 32'h0, 32'h0, 4'b0000, 32'h0);
    run_op(4'b0011, 4'b0000, 1'b0, 32'h102, 32'h0, 0, 3, 32'h80017FFF, 32'hFFFF8001, 32'h100, 4'b1100, 32'h0);
    run_op(4'b0011, 4'b0000, 1'b1, 32'h100, 32'h0, 2, 1, 32'h1234F00F, 32'h0000F00F, 32'h100, 4'b0011, 32'h0);
    run_op(4'b0000, 4'b0001, 1'b0, 32'h05, 32'h0000005A, 1, 3, 32'h0, 32'h0, 32'h04, 4'b0010, 32'h5A5A5A5A);
    run_op(4'b0000, 4'b1111, 1'b0, 32'h08, 32'hCAFEF00D, 0, 1, 32'h0, 32'h0, 32'h08, 4'b1111, 32'hCAFEF00D);
    run_op(4'b0001, 4'b0001, 1'b0, 32'h10, 32'h0, 0, 1, 32'h0, 32'h0, 32'h0, 4'b0000, 32'h0);
    run_op(4'b0111, 4'b0000, 1'b0, 32'h10, 32'h0, 0, 1, 32'h0, 32'h0, 32'h0, 4'b0000, 32'h0);
    run_op(4'b1111, 4'b0000, 1'b0, 32'h200, 32'h0, 100, 1, 32'h11111111, 32'h0, 32'h200, 4'b1111, 32'h0);

    // Flushed access never starts.
    MemRead_i = 4'b1111; ALUResult_i = 32'h100; flush_i = 1'b1;
    e = '0; exp_q.push_back(e);
    next_cycle();
    clear_inputs();
    next_cycle();

    // Reset while waiting for the response.
    MemRead_i = 4'b1111; ALUResult_i = 32'h100;
    e = '0; e.stall = 1'b1; exp_q.push_back(e);
    next_cycle();
    dmem.gnt = 1'b1;
    e = '0; e.stall = 1'b1; e.req = 1'b1; e.addr = 32'h100; e.be = 4'b1111;
    exp_q.push_back(e);
    next_cycle();
    dmem.gnt = 1'b0;
    e = '0; e.stall = 1'b1; exp_q.push_back(e);
    @(negedge CLK);
    #2;
    RST = 1'b1;
    clear_inputs();
    #1;
    chk("arst_stall", 32'(stall_o), 32'h0);
    chk("arst_req", 32'(dmem.req), 32'h0);
    chk("arst_done", 32'(done_o), 32'h0);
    chk("arst_rdata", ReadData_o, 32'h0);
    chk("arst_be", 32'(dmem.be), 32'h0);
    chk("arst_state", 32'(state_dbg), 32'h0);
    next_cycle();
    RST = 1'b0;
    next_cycle();
    run_op(4'b1111, 4'b0000, 1'b0, 32'h104, 32'h0, 1, 2, 32'h12345678, 32'h12345678, 32'h104, 4'b1111, 32'h0);
    next_cycle();
    next_cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
